// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station with CDB snooping and valid/ready dispatch
//
// Purpose: holds up to DEPTH issued instructions, each with an operation, two
// operand values (Vj/Vk) and their producer tags (Qj/Qk). Pending tags are
// resolved by snooping the common data bus. One ready entry per cycle is
// presented to the functional unit.
//
// Optional feature macro: RS_OLDEST_FIRST_EN
//   undefined : dispatch picks the lowest-index ready entry
//   defined   : dispatch picks the oldest ready entry (per-entry age counters),
//               and a presented entry keeps selection until accepted
//
// Ports:
//   clk, nRST                 clock (rising edge), asynchronous active-low reset
//   issue_en/op/vj/qj/vk/qk   issue request and instruction fields from control
//   issue_accept, issue_tag   entry written this edge and its tag
//   isFull                    all entries busy
//   cdb_valid/tag/data        common data bus broadcast
//   alu_valid/ready           dispatch handshake to the functional unit
//   alu_op/a/b/tag            fields of the presented entry (0 when not valid)

module reservation_station #(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int ALUOP_W  = 2,
    parameter int TAG_BASE = 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               issue_en,
    input  logic [ALUOP_W-1:0] issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [TAG_W-1:0]   issue_qj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic [TAG_W-1:0]   issue_qk,
    output logic               issue_accept,
    output logic [TAG_W-1:0]   issue_tag,
    output logic               isFull,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [TAG_W-1:0]   alu_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [ALUOP_W-1:0] op_q [DEPTH];
    logic [ALUOP_W-1:0] op_d [DEPTH];
    logic [DATA_W-1:0]  vj_q [DEPTH];
    logic [DATA_W-1:0]  vj_d [DEPTH];
    logic [DATA_W-1:0]  vk_q [DEPTH];
    logic [DATA_W-1:0]  vk_d [DEPTH];
    logic [TAG_W-1:0]   qj_q [DEPTH];
    logic [TAG_W-1:0]   qj_d [DEPTH];
    logic [TAG_W-1:0]   qk_q [DEPTH];
    logic [TAG_W-1:0]   qk_d [DEPTH];

`ifdef RS_OLDEST_FIRST_EN
    localparam int AGE_W = $clog2(DEPTH) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    logic [AGE_W-1:0] age_q [DEPTH];
    logic [AGE_W-1:0] age_d [DEPTH];
    logic [AGE_W-1:0] best_age;
    // Remembers the entry left waiting on alu_ready so an older entry made
    // ready later by the CDB cannot steal the functional-unit port.
    logic             hold_q, hold_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
`endif

    logic [DEPTH-1:0] ready;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             cdb_hit;

    assign cdb_hit = cdb_valid && (cdb_tag != '0);

    // Lowest-index free entry; defaults to entry 0 so issue_tag reads TAG_BASE when full.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    // Dispatch selection from registered state only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Strict '>' leaves ties with the lower index.
            if (ready[i] && (!sel_found || (age_q[i] > best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age_q[i];
            end
        end
        if (hold_q) begin
            sel_found = 1'b1;
            sel_idx   = hold_idx_q;
        end
`else
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
`endif
    end

    assign isFull       = &busy_q;
    assign issue_accept = issue_en && !isFull && nRST;
    assign issue_tag    = TAG_W'(TAG_BASE) + TAG_W'(free_idx);

    assign alu_valid = sel_found;
    assign alu_op    = sel_found ? op_q[sel_idx] : '0;
    assign alu_a     = sel_found ? vj_q[sel_idx] : '0;
    assign alu_b     = sel_found ? vk_q[sel_idx] : '0;
    assign alu_tag   = sel_found ? (TAG_W'(TAG_BASE) + TAG_W'(sel_idx)) : '0;

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
`ifdef RS_OLDEST_FIRST_EN
        age_d      = age_q;
        hold_d     = sel_found && !alu_ready;
        hold_idx_d = sel_idx;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && cdb_hit) begin
                if (qj_q[i] == cdb_tag) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = '0;
                end
                if (qk_q[i] == cdb_tag) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = '0;
                end
            end
        end
        // Release targets a busy entry, allocation a free one: never the same slot.
        if (sel_found && alu_ready) begin
            busy_d[sel_idx] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_op;
            // Bypass a broadcast in the issue cycle so it is not missed.
            if (cdb_hit && (issue_qj == cdb_tag)) begin
                vj_d[free_idx] = cdb_data;
                qj_d[free_idx] = '0;
            end else begin
                vj_d[free_idx] = issue_vj;
                qj_d[free_idx] = issue_qj;
            end
            if (cdb_hit && (issue_qk == cdb_tag)) begin
                vk_d[free_idx] = cdb_data;
                qk_d[free_idx] = '0;
            end else begin
                vk_d[free_idx] = issue_vk;
                qk_d[free_idx] = issue_qk;
            end
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            age_d[free_idx] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
                age_q[i] <= '0;
`endif
            end
`ifdef RS_OLDEST_FIRST_EN
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
`endif
        end else begin
            busy_q <= busy_d;
            op_q   <= op_d;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
`ifdef RS_OLDEST_FIRST_EN
            age_q      <= age_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station

module tb_reservation_station;

    logic        clk;
    logic        nRST;
    logic        issue_en;
    logic [1:0]  issue_op;
    logic [31:0] issue_vj;
    logic [3:0]  issue_qj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qk;
    logic        issue_accept;
    logic [3:0]  issue_tag;
    logic        isFull;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [1:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_tag;

    int n_vec;
    int n_bad;

    reservation_station dut (
        .clk          (clk),
        .nRST         (nRST),
        .issue_en     (issue_en),
        .issue_op     (issue_op),
        .issue_vj     (issue_vj),
        .issue_qj     (issue_qj),
        .issue_vk     (issue_vk),
        .issue_qk     (issue_qk),
        .issue_accept (issue_accept),
        .issue_tag    (issue_tag),
        .isFull       (isFull),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_tag      (alu_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en  = 1'b0;
        cdb_valid = 1'b0;
        alu_ready = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic [3:0] qk);
        issue_en = 1'b1;
        issue_op = op;
        issue_vj = vj;
        issue_qj = qj;
        issue_vk = vk;
        issue_qk = qk;
    endtask

    task automatic do_reset();
        #2;
        nRST = 1'b0;
        #1;
        idle();
        #3;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        logic [3:0] order [3];
        n_vec = 0;
        n_bad = 0;
        nRST = 1'b0;
        idle();
        issue_en = 1'b1;
        issue_op = '0; issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
        cdb_tag = '0; cdb_data = '0;
        #3;
        check("rst_isFull", isFull, 0);
        check("rst_accept", issue_accept, 0);
        check("rst_alu_valid", alu_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_tag", alu_tag, 0);
        check("rst_issue_tag", issue_tag, 1);
        issue_en = 1'b0;
        #8;
        nRST = 1'b1;
        tick();

        // Basic issue and dispatch.
        set_issue(2'd0, 32'd5, 4'd0, 32'd7, 4'd0);
        #1;
        check("t1_accept", issue_accept, 1);
        check("t1_issue_tag", issue_tag, 1);
        check("t1_valid_same_cycle", alu_valid, 0);
        tick();
        idle();
        #1;
        check("t1_alu_valid", alu_valid, 1);
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 7);
        check("t1_alu_tag", alu_tag, 1);
        alu_ready = 1'b1;
        tick();
        idle();
        #1;
        check("t1_released", alu_valid, 0);

        // Fill with pending operands, stall a fourth issue, resolve by CDB.
        for (int i = 0; i < 3; i++) begin
            set_issue(2'd1, 32'd0, 4'd2, 32'(i + 1), 4'd0);
            #1;
            check("t2_issue_tag", issue_tag, 4'(i + 1));
            tick();
        end
        idle();
        set_issue(2'd1, 32'hDEAD, 4'd0, 32'hBEEF, 4'd0);
        #1;
        check("t2_isFull", isFull, 1);
        check("t2_fourth_accept", issue_accept, 0);
        check("t2_not_ready", alu_valid, 0);
        tick();
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h10;
        #1;
        check("t2_cdb_latency", alu_valid, 0);
        tick();
        idle();
        #1;
        check("t2_alu_valid", alu_valid, 1);
        check("t2_alu_a", alu_a, 32'h10);
        for (int i = 0; i < 3; i++) begin
            alu_ready = 1'b1;
            #1;
            check("t2_drain_tag", alu_tag, 4'(i + 1));
            check("t2_drain_b", alu_b, 32'(i + 1));
            tick();
        end
        idle();
        #1;
        check("t2_empty", alu_valid, 0);

        // Issue in the same cycle as the broadcast it waits on; then hold.
        set_issue(2'd2, 32'd1, 4'd0, 32'd0, 4'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hAB;
        #1;
        check("t3_accept", issue_accept, 1);
        tick();
        idle();
        #1;
        check("t3_alu_valid", alu_valid, 1);
        check("t3_alu_b", alu_b, 32'hAB);
        for (int c = 0; c < 4; c++) begin
            check("t4_hold_valid", alu_valid, 1);
            check("t4_hold_op", alu_op, 2);
            check("t4_hold_a", alu_a, 1);
            check("t4_hold_b", alu_b, 32'hAB);
            check("t4_hold_tag", alu_tag, 1);
            tick();
        end
        alu_ready = 1'b1;
        tick();
        idle();
        #1;
        check("t4_released", alu_valid, 0);

        // Full station: release and issue in the same cycle.
        for (int i = 0; i < 3; i++) begin
            set_issue(2'd3, 32'(i + 1), 4'd0, 32'd0, 4'd0);
            tick();
        end
        idle();
        set_issue(2'd3, 32'h55, 4'd0, 32'd0, 4'd0);
        alu_ready = 1'b1;
        #1;
        check("t5_isFull", isFull, 1);
        check("t5_accept_blocked", issue_accept, 0);
        check("t5_release_tag", alu_tag, 1);
        tick();
        alu_ready = 1'b0;
        #1;
        check("t5_not_full", isFull, 0);
        check("t5_accept", issue_accept, 1);
        check("t5_reuse_tag", issue_tag, 1);
        tick();
        idle();
        #1;
        check("t5_full_again", isFull, 1);
`ifdef RS_OLDEST_FIRST_EN
        check("t5_first_after_refill", alu_tag, 2);
`else
        check("t5_first_after_refill", alu_tag, 1);
        check("t5_first_a", alu_a, 32'h55);
`endif
        for (int i = 0; i < 3; i++) begin
            alu_ready = 1'b1;
            tick();
        end
        idle();
        #1;
        check("t5_empty", alu_valid, 0);

        // Dispatch order after freeing and reissuing entry 0.
        set_issue(2'd0, 32'hA0, 4'd0, 32'd0, 4'd0);
        tick();
        set_issue(2'd0, 32'hA1, 4'd9, 32'd0, 4'd0);
        tick();
        set_issue(2'd0, 32'hA2, 4'd9, 32'd0, 4'd0);
        tick();
        idle();
        alu_ready = 1'b1;
        #1;
        check("t6_free0_tag", alu_tag, 1);
        tick();
        idle();
        set_issue(2'd0, 32'hA3, 4'd9, 32'd0, 4'd0);
        #1;
        check("t6_reissue_tag", issue_tag, 1);
        tick();
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h99;
        tick();
        idle();
`ifdef RS_OLDEST_FIRST_EN
        order[0] = 4'd2; order[1] = 4'd3; order[2] = 4'd1;
`else
        order[0] = 4'd1; order[1] = 4'd2; order[2] = 4'd3;
`endif
        for (int i = 0; i < 3; i++) begin
            alu_ready = 1'b1;
            #1;
            check("t6_order_valid", alu_valid, 1);
            check("t6_order_tag", alu_tag, order[i]);
            check("t6_order_a", alu_a, 32'h99);
            tick();
        end
        idle();

        // Asynchronous reset while an entry is presented.
        for (int i = 0; i < 3; i++) begin
            set_issue(2'd1, 32'd4, 4'd0, 32'd4, 4'd0);
            tick();
        end
        idle();
        #1;
        check("t7_pre_full", isFull, 1);
        check("t7_pre_valid", alu_valid, 1);
        #1;
        nRST = 1'b0;
        #1;
        check("t7_rst_valid", alu_valid, 0);
        check("t7_rst_isFull", isFull, 0);
        check("t7_rst_tag", alu_tag, 0);
        check("t7_rst_issue_tag", issue_tag, 1);
        #2;
        nRST = 1'b1;
        tick();
        tick();
        check("t7_post_valid", alu_valid, 0);
        check("t7_post_full", isFull, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
